// File: rtl/time_frame_pkg.sv
// Shared types and constants for the time snapshot framer: FSM states, frame sizes, field slots.
// Purely declarative; no logic, no latency, no flow control.
package time_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SEND    = 2'd2
    } state_e;

    localparam int CONV_CYCLES    = 6;
    localparam int FRAME_LEN_CK   = 7;
    localparam int FRAME_LEN_NOCK = 6;
    localparam int IDX_W          = 3;
    localparam int CNT_W          = 3;
    localparam int FIELD_W        = 6;
    localparam int NUM_FIELDS     = 5;

    localparam int MONTHS  = 0;
    localparam int DAYS    = 1;
    localparam int HOURS   = 2;
    localparam int MINUTES = 3;
    localparam int SECONDS = 4;

    function automatic logic [7:0] bcd_byte(input logic [3:0] tens, input logic [3:0] ones);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_digit_split.sv
// One field's binary-to-BCD stage: load a value, then peel off a ten per enabled cycle.
// One subtract per enable; no flow control, the owner decides how many enables to give.
module bcd_digit_split #(
    parameter int W = 6
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] val_i,
    output logic [3:0]   ones_o,
    output logic [3:0]   tens_o
);

    logic [W-1:0] work_q, work_d;
    logic [3:0]   tens_q, tens_d;
    logic         ge10;

    assign ge10 = (work_q >= W'(10));

    always_comb begin
        work_d = work_q;
        tens_d = tens_q;
        if (load_i) begin
            work_d = val_i;
            tens_d = '0;
        end else if (en_i && ge10) begin
            work_d = work_q - W'(10);
            tens_d = tens_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            work_q <= '0;
            tens_q <= '0;
        end else begin
            work_q <= work_d;
            tens_q <= tens_d;
        end
    end

    // After enough enables the residue is below ten, so its low nibble is the ones digit.
    assign ones_o = work_q[3:0];
    assign tens_o = tens_q;

endmodule

// File: rtl/time_frame_tx.sv
// Snapshots clock fields, converts to BCD in 6 cycles, sends HEADER+5 BCD bytes(+XOR) on valid/ready.
// First byte 6 cycles after snap; bytes hold while tx_ready is low; snaps while busy are dropped.
module time_frame_tx
    import time_frame_pkg::*;
#(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter bit         CHECKSUM_EN = 1'b1
) (
    input  logic       SysClock,
    input  logic       reset_n,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    input  logic [4:0] days,
    input  logic [3:0] months,
    input  logic       snap,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       tx_last,
    output logic       busy,
    output logic       snap_drop
);

    localparam logic [IDX_W-1:0] LAST_IDX =
        IDX_W'((CHECKSUM_EN ? FRAME_LEN_CK : FRAME_LEN_NOCK) - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d, nxt_idx;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               tx_last_q, tx_last_d;
    logic               busy_q, busy_d;
    logic               snap_drop_q, snap_drop_d;
    logic               load, conv_en;

    logic [FIELD_W-1:0] field_bin  [NUM_FIELDS];
    logic [3:0]         ones       [NUM_FIELDS];
    logic [3:0]         tens       [NUM_FIELDS];
    logic [7:0]         field_byte [NUM_FIELDS];
    logic [7:0]         cksum, nxt_byte;

    assign field_bin[MONTHS]  = {2'b00, months};
    assign field_bin[DAYS]    = {1'b0, days};
    assign field_bin[HOURS]   = {1'b0, hours};
    assign field_bin[MINUTES] = minutes;
    assign field_bin[SECONDS] = seconds;

    for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_split
        bcd_digit_split #(.W(FIELD_W)) u_split (
            .clk_i  (SysClock),
            .rst_ni (reset_n),
            .load_i (load),
            .en_i   (conv_en),
            .val_i  (field_bin[f]),
            .ones_o (ones[f]),
            .tens_o (tens[f])
        );
    end

    always_comb begin
        cksum = '0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            field_byte[f] = bcd_byte(tens[f], ones[f]);
            cksum         = cksum ^ field_byte[f];
        end
    end

    // Byte to present after the current one is accepted; the digits are stable throughout SEND.
    assign nxt_idx = idx_q + 3'd1;

    always_comb begin
        case (nxt_idx)
            3'd0:    nxt_byte = HEADER;
            3'd1:    nxt_byte = field_byte[MONTHS];
            3'd2:    nxt_byte = field_byte[DAYS];
            3'd3:    nxt_byte = field_byte[HOURS];
            3'd4:    nxt_byte = field_byte[MINUTES];
            3'd5:    nxt_byte = field_byte[SECONDS];
            default: nxt_byte = cksum;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        busy_d      = busy_q;
        snap_drop_d = 1'b0;
        load        = 1'b0;
        conv_en     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (snap) begin
                    load    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                snap_drop_d = snap;
                conv_en     = 1'b1;
                cnt_d       = cnt_q + 3'd1;
                if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
                    state_d    = SEND;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HEADER;
                    tx_last_d  = 1'b0;
                end
            end
            SEND: begin
                snap_drop_d = snap;
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        tx_data_d  = '0;
                        busy_d     = 1'b0;
                    end else begin
                        idx_d     = nxt_idx;
                        tx_data_d = nxt_byte;
                        tx_last_d = (nxt_idx == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SysClock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            snap_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
            busy_q      <= busy_d;
            snap_drop_q <= snap_drop_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign tx_last   = tx_last_q;
    assign busy      = busy_q;
    assign snap_drop = snap_drop_q;

endmodule
